// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the two-master memory bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_e;

  typedef enum logic {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_e;

  // One-hot grant vector for a given owner.
  function automatic logic [1:0] owner_onehot(input owner_e owner);
    return (owner == OWNER_M1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Valid/ready memory bus. The requester uses the master view; the responder uses the slave view.
interface mem_bus_arbiter_if;
  logic        valid;
  logic        instr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, instr, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, instr, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mem_arb_timer.sv
// Saturating bus-watchdog counter with clear, load and enable; expire_o flags the last allowed cycle.
module mem_arb_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          en_i,
  output logic          expire_o
);

  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  // Next count: clear beats load beats increment; the count parks at CNT_MAX instead of wrapping.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = (load_val_i > CNT_MAX) ? CNT_MAX : load_val_i;
    end else if (en_i && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register, cleared the moment reset_n falls.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign expire_o = (count_q == CNT_LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one valid/ready memory bus between two masters, with a hung-bus watchdog.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'h0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  mem_bus_arbiter_if.slave          m0,
  mem_bus_arbiter_if.slave          m1,
  mem_bus_arbiter_if.master         s,
  output logic [1:0]                grant,
  output logic                      timeout_err
);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  owner_e      last_owner_q, last_owner_d;

  logic        req_valid, req_instr;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        expire;

  // Request fields of whichever master currently owns the bus.
  always_comb begin
    if (owner_q == OWNER_M1) begin
      req_valid = m1.valid;
      req_instr = m1.instr;
      req_addr  = m1.addr;
      req_wdata = m1.wdata;
      req_wstrb = m1.wstrb;
    end else begin
      req_valid = m0.valid;
      req_instr = m0.instr;
      req_addr  = m0.addr;
      req_wdata = m0.wdata;
      req_wstrb = m0.wstrb;
    end
  end

  // Arbitration FSM: next state, bus forwarding and the response routed back to the owner.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    s.valid      = 1'b0;
    s.instr      = 1'b0;
    s.addr       = '0;
    s.wdata      = '0;
    s.wstrb      = '0;
    grant        = 2'b00;
    timeout_err  = 1'b0;
    resp_ready   = 1'b0;
    resp_rdata   = '0;

    unique case (state_q)
      IDLE: begin
        if (m0.valid || m1.valid) begin
          state_d = BUSY;
          if (m0.valid && m1.valid) begin
            owner_d = (last_owner_q == OWNER_M0) ? OWNER_M1 : OWNER_M0;
          end else begin
            owner_d = m1.valid ? OWNER_M1 : OWNER_M0;
          end
        end
      end
      BUSY: begin
        grant   = owner_onehot(owner_q);
        s.valid = req_valid;
        s.instr = req_instr;
        s.addr  = req_addr;
        s.wdata = req_wdata;
        s.wstrb = req_wstrb;
        if (!req_valid) begin
          // Owner abandoned its request: release the bus without answering.
          state_d = IDLE;
        end else if (s.ready) begin
          // Completion outranks a watchdog expiring in the same cycle.
          resp_ready   = 1'b1;
          resp_rdata   = s.rdata;
          last_owner_d = owner_q;
          state_d      = IDLE;
        end else if (expire) begin
          state_d = ERR;
        end
      end
      ERR: begin
        grant        = owner_onehot(owner_q);
        resp_ready   = 1'b1;
        resp_rdata   = ERR_RDATA;
        timeout_err  = 1'b1;
        last_owner_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    m0.ready = resp_ready && (owner_q == OWNER_M0);
    m0.rdata = (resp_ready && (owner_q == OWNER_M0)) ? resp_rdata : '0;
    m1.ready = resp_ready && (owner_q == OWNER_M1);
    m1.rdata = (resp_ready && (owner_q == OWNER_M1)) ? resp_rdata : '0;
  end

  // State, owner and round-robin history; last_owner resets to m1 so m0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: reset is asynchronous so the bus is released immediately, without waiting for a clock edge.
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= OWNER_M0;
      last_owner_q <= OWNER_M1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Watchdog runs only while BUSY and restarts whenever the bus is about to leave BUSY.
  mem_arb_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_i    (state_d != BUSY),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (state_q == BUSY),
    .expire_o   (expire)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: responses are scoreboarded against expectations queued at request time.
module tb_mem_bus_arbiter;

  localparam int unsigned TIMEOUT    = 8;
  localparam logic [31:0] ERR_VALUE  = 32'h0;

  typedef struct packed {
    logic        who;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] grant;
  logic       timeout_err;

  int    checks = 0;
  int    errors = 0;
  resp_t sb_q[$];

  mem_bus_arbiter_if m0_bus ();
  mem_bus_arbiter_if m1_bus ();
  mem_bus_arbiter_if s_bus ();

  mem_bus_arbiter #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .ERR_RDATA      (ERR_VALUE)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .m0          (m0_bus),
    .m1          (m1_bus),
    .s           (s_bus),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input bit who, input logic instr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wstrb,
                     input bit expect_resp, input logic [31:0] exp_rdata, input logic exp_err);
    resp_t r;
    if (!who) begin
      m0_bus.valid = 1'b1; m0_bus.instr = instr; m0_bus.addr = addr;
      m0_bus.wdata = wdata; m0_bus.wstrb = wstrb;
    end else begin
      m1_bus.valid = 1'b1; m1_bus.instr = instr; m1_bus.addr = addr;
      m1_bus.wdata = wdata; m1_bus.wstrb = wstrb;
    end
    if (expect_resp) begin
      r.who = who; r.err = exp_err; r.rdata = exp_rdata;
      sb_q.push_back(r);
    end
  endtask

  task automatic drop(input bit who);
    if (!who) m0_bus.valid = 1'b0;
    else      m1_bus.valid = 1'b0;
  endtask

  // Waits (bounded) for s_valid with the expected grant; returns the number of cycles waited.
  task automatic wait_grant(input logic [1:0] exp_grant, output int waited);
    waited = 0;
    while (!(s_bus.valid === 1'b1 && grant === exp_grant) && waited < 30) begin
      cyc();
      waited++;
    end
    check("grant_wait", {grant, s_bus.valid}, {exp_grant, 1'b1});
  endtask

  // Slave answers after wait_cycles, then the owner withdraws its request.
  task automatic serve(input bit who, input int wait_cycles, input logic [31:0] rdata);
    repeat (wait_cycles) cyc();
    s_bus.ready = 1'b1;
    s_bus.rdata = rdata;
    cyc();
    s_bus.ready = 1'b0;
    s_bus.rdata = '0;
    drop(who);
  endtask

  // Response monitor: every ready must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    resp_t got, exp_r;
    if (reset_n === 1'b1) begin
      if (m0_bus.ready === 1'b1 || m1_bus.ready === 1'b1) begin
        got.who   = m1_bus.ready;
        got.err   = timeout_err;
        got.rdata = (m1_bus.ready === 1'b1) ? m1_bus.rdata : m0_bus.rdata;
        check("ready_exclusive", {62'd0, m1_bus.ready, m0_bus.ready} & 64'h3, {62'd0, m1_bus.ready, ~m1_bus.ready});
        if (sb_q.size() == 0) begin
          check("unexpected_ready", {62'd0, m1_bus.ready, m0_bus.ready}, 64'd0);
        end else begin
          exp_r = sb_q.pop_front();
          check("resp", got, exp_r);
        end
      end else if (timeout_err !== 1'b0) begin
        check("stray_timeout_err", timeout_err, 1'b0);
      end
      if (grant != 2'b00) begin
        check("nonowner_ready", grant[0] ? m1_bus.ready : m0_bus.ready, 1'b0);
      end
    end
  end

  initial begin : stim
    int w;
    int n;
    reset_n = 1'b0;
    m0_bus.valid = 0; m0_bus.instr = 0; m0_bus.addr = 0; m0_bus.wdata = 0; m0_bus.wstrb = 0;
    m1_bus.valid = 0; m1_bus.instr = 0; m1_bus.addr = 0; m1_bus.wdata = 0; m1_bus.wstrb = 0;
    s_bus.ready = 0; s_bus.rdata = 0;

    // Reset values while reset_n is held low.
    #3;
    check("rst_s_addr", s_bus.addr, 32'h0);
    check("rst_s_wdata", s_bus.wdata, 32'h0);
    check("rst_ctrl", {s_bus.valid, s_bus.instr, s_bus.wstrb, grant, timeout_err, m0_bus.ready, m1_bus.ready}, 0);
    check("rst_rdata", {m0_bus.rdata, m1_bus.rdata}, 64'h0);
    #9 reset_n = 1'b1;
    cyc();
    cyc();

    // m0 read, slave answers 3 cycles after s_valid.
    req(0, 1'b0, 32'h4000_0010, 32'h0, 4'h0, 1, 32'hcafe_f00d, 1'b0);
    wait_grant(2'b01, w);
    check("t1_latency", w, 1);
    check("t1_addr", s_bus.addr, 32'h4000_0010);
    check("t1_read_fields", {s_bus.wstrb, s_bus.instr}, 5'h0);
    serve(0, 3, 32'hcafe_f00d);
    check("t1_bubble", {s_bus.valid, grant}, 3'b000);
    cyc();

    // m1 takes the bus, then reset hits mid-transaction.
    req(1, 1'b1, 32'h0000_0100, 32'h0, 4'h0, 0, 32'h0, 1'b0);
    wait_grant(2'b10, w);
    cyc();
    #2 reset_n = 1'b0;
    #1;
    check("rst_async", {s_bus.valid, grant, m0_bus.ready, m1_bus.ready, timeout_err}, 6'b0);
    @(negedge clk);
    // Both masters request together out of reset: strict alternation m0, m1, m0, m1.
    req(0, 1'b0, 32'h0000_0a00, 32'h0, 4'h0, 1, 32'hd000_0000, 1'b0);
    req(1, 1'b1, 32'h0000_0b00, 32'h0, 4'h0, 1, 32'hd000_0001, 1'b0);
    reset_n = 1'b1;
    wait_grant(2'b01, w);
    check("tie_latency", w, 1);
    check("alt0_addr", s_bus.addr, 32'h0000_0a00);
    serve(0, 1, 32'hd000_0000);
    check("alt0_bubble", {s_bus.valid, grant}, 3'b000);
    req(0, 1'b0, 32'h0000_0a04, 32'h0, 4'h0, 1, 32'hd000_0002, 1'b0);
    cyc();
    check("alt1_grant", {s_bus.valid, grant, s_bus.instr}, 4'b1101);
    check("alt1_addr", s_bus.addr, 32'h0000_0b00);
    serve(1, 2, 32'hd000_0001);
    check("alt1_bubble", {s_bus.valid, grant}, 3'b000);
    req(1, 1'b0, 32'h0000_0b04, 32'h0, 4'h0, 1, 32'hd000_0003, 1'b0);
    cyc();
    check("alt2_grant", {s_bus.valid, grant}, 3'b101);
    check("alt2_addr", s_bus.addr, 32'h0000_0a04);
    serve(0, 0, 32'hd000_0002);
    cyc();
    check("alt3_grant", {s_bus.valid, grant}, 3'b110);
    check("alt3_addr", s_bus.addr, 32'h0000_0b04);
    serve(1, 0, 32'hd000_0003);
    cyc();

    // m1 write with no slave response: watchdog terminates it.
    req(1, 1'b0, 32'h2000_0000, 32'h1234_5678, 4'hf, 1, ERR_VALUE, 1'b1);
    wait_grant(2'b10, w);
    check("to_wdata", s_bus.wdata, 32'h1234_5678);
    check("to_wstrb", s_bus.wstrb, 4'hf);
    n = 0;
    while (s_bus.valid === 1'b1 && n < 20) begin
      n++;
      cyc();
    end
    check("to_valid_len", n, TIMEOUT);
    check("to_err_cycle", {timeout_err, m1_bus.ready, m0_bus.ready, grant, s_bus.valid}, 6'b110100);
    drop(1);
    cyc();
    check("to_idle", {timeout_err, m1_bus.ready, s_bus.valid, grant}, 5'b0);

    // Slave ready lands on the expiry cycle: a normal completion, no error pulse.
    req(0, 1'b0, 32'h3000_0000, 32'h0, 4'h0, 1, 32'h5a5a_0001, 1'b0);
    wait_grant(2'b01, w);
    serve(0, TIMEOUT - 1, 32'h5a5a_0001);
    check("edge_no_err", {timeout_err, s_bus.valid, grant}, 4'b0);
    cyc();

    // m0 abandons its request mid-transaction, then m1 is served normally.
    req(0, 1'b0, 32'h4000_0020, 32'h0, 4'h0, 0, 32'h0, 1'b0);
    wait_grant(2'b01, w);
    cyc();
    drop(0);
    #1;
    check("drop_s_valid", {s_bus.valid, m0_bus.ready}, 2'b00);
    cyc();
    check("drop_idle", grant, 2'b00);
    req(1, 1'b0, 32'h4000_0030, 32'h0, 4'h0, 1, 32'h7777_0000, 1'b0);
    wait_grant(2'b10, w);
    check("drop_m1_latency", w, 1);
    serve(1, 1, 32'h7777_0000);
    cyc();
    cyc();
    check("sb_drain", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
